adc_frame_aligner: RTL and testbench
====================================

# adc_frame_aligner

Parametrised frame-alignment and sample-unpacking stage for multi-lane LVDS ADCs. It sits directly behind the SERDES deserializer, in the divided ADC clock domain. It hunts for a programmable frame pattern by pulsing the deserializer's bitslip, declares and monitors lock, and unpacks per-channel samples into fixed-width words with a valid strobe. It supports N channels of L lanes each, and offset-binary or two's-complement output.

## Interface
- NUM_CH, 2: ADC channels.
- LANES, 2: serial lanes per channel.
- SER, 7: deserialization factor, i.e. bits per lane per frame; SAMPLE_W = LANES*SER.
- OUT_W, 16: output word width per channel; must be ≥ SAMPLE_W.
- FRAME_PATTERN, 7'b1111000: expected SER-bit frame word when aligned.
- LOCK_CNT, 16: consecutive pattern matches required to declare lock.
- ERR_LIMIT, 4: consecutive mismatches while locked that cause unlock.
- SLIP_WAIT, 3: settle cycles after each bitslip pulse before the next compare.

Ports:
- clk  in  1  divided ADC clock; the only clock.
- reset_n  in  1  synchronous, active-low reset.
- frame_in  in  SER  deserialized frame-clock word.
- lane_in  in  NUM_CH*LANES*SER  lane (c,l) at [(c*LANES+l)*SER +: SER].
- twos_comp  in  1  1 = invert sample MSB and sign-extend; 0 = zero-extend.
- resync  in  1  single-cycle request to drop lock and re-hunt.
- bitslip  out  1  one-cycle pulse to the deserializer.
- data_out  out  NUM_CH*OUT_W  channel c at [c*OUT_W +: OUT_W].
- data_valid  out  1  data_out holds a sample from an aligned frame.
- locked  out  1  alignment state is LOCKED.
- align_fail  out  1  sticky flag: 2*SER slips without lock.
- slip_count  out  8  slips since last reset/resync/unlock, saturating at 255.
- unlock_count  out  8  LOCKED→HUNT transitions, saturating at 255.

## Operation
- match = (frame_in == FRAME_PATTERN).
- Channel c sample = lane_in[c*LANES*SER +: SAMPLE_W]; lane 0 in the LSBs.
- Format:
  - twos_comp=0: the sample is zero-extended to OUT_W.
  - twos_comp=1: MSB[SAMPLE_W-1] is inverted, then the result is sign-extended to OUT_W.
- FSM states: HUNT, SETTLE, CHECK, LOCKED.
  - HUNT: if match, go to CHECK with match count = 1. Otherwise pulse bitslip, increment slip_count, and go to SETTLE.
  - SETTLE: wait SLIP_WAIT cycles, ignoring frame_in, then go to HUNT.
  - CHECK: a match increments the count; on reaching LOCK_CNT, go to LOCKED. A mismatch pulses bitslip, increments slip_count, and goes to SETTLE.
  - LOCKED: a match clears the error count. A mismatch increments it; on reaching ERR_LIMIT, go to HUNT, increment unlock_count, and clear slip_count.
- align_fail sets when slip_count reaches 2*SER while not LOCKED.
  - Hunting continues after align_fail sets.
  - align_fail is cleared only by reset or resync; reaching LOCKED does not clear it.
- resync:
  - From any state: go to HUNT, clear slip_count, align_fail and all match/error counts.
  - resync does not increment unlock_count.
  - resync has priority over every other transition in the same cycle.
- data_valid = 1 only for frames sampled in LOCKED with match = 1. Mismatching frames inside LOCKED are dropped, with data_valid = 0.
- data_out updates every cycle regardless of data_valid.

## Timing
- Reset values: bitslip, data_out, data_valid, locked, align_fail, slip_count and unlock_count are all 0; state = HUNT.
- data_out and data_valid are registered, with latency 1 cycle from lane_in/frame_in.
- locked is a registered decode of the state. It rises in the cycle after the LOCK_CNT-th match.
  - The first data_valid frame is the first frame after locked rises.
- bitslip is registered and exactly 1 cycle wide. Consecutive pulses are spaced by at least SLIP_WAIT+1 cycles.
- Worst-case lock from a misaligned start: SER slips × (SLIP_WAIT+1) cycles, plus LOCK_CNT cycles.
- Counters saturate at 255; they never wrap.
- A reset mid-SETTLE or mid-CHECK returns to HUNT with no bitslip pulse in the reset cycle.

## Structure
- Package adc_rx_pkg holds:
  - the state enum (HUNT/SETTLE/CHECK/LOCKED);
  - the default FRAME_PATTERN constant;
  - the SAMPLE_W derivation function.
- Sub-module adc_sample_format:
  - one instance per channel, in a generate loop;
  - inputs: SAMPLE_W raw sample and twos_comp; output: OUT_W word;
  - combinational; the register stage stays in the top level.
- The FSM and counters live in adc_frame_aligner.

## Test plan
- Aligned start, frame_in = 7'b1111000 constantly: locked rises after 16 matches, data_valid = 1 from the next cycle, slip_count = 0, no bitslip pulse.
- Misalignment of 3 bits, modelled by a rotating deserializer: exactly 3 bitslip pulses spaced 4 cycles apart, then lock; slip_count = 3.
- twos_comp=1 with raw sample 14'h0000 → data_out channel = 16'hE000; twos_comp=0 with 14'h3FFF → 16'h3FFF.
- While locked, inject 3 bad frames → stays locked, data_valid = 0 on exactly those 3 frames. Inject 4 consecutive bad frames → unlock, unlock_count = 1, re-hunt.
- Frame never matches → align_fail = 1 after the 14th slip, hunting continues, slip_count saturates at 255.
- resync asserted in the same cycle as the LOCK_CNT-th match → HUNT, locked stays 0, align_fail = 0, unlock_count unchanged.

Source files
------------

// File: rtl/adc_rx_pkg.sv
// Shared types and helpers for the LVDS ADC receive path: alignment FSM states,
// default frame word and sample-width derivation.
package adc_rx_pkg;

    typedef enum logic [1:0] {
        ST_HUNT,
        ST_SETTLE,
        ST_CHECK,
        ST_LOCKED
    } align_state_e;

    localparam logic [6:0] DEFAULT_FRAME_PATTERN = 7'b1111000;

    function automatic int sample_width(input int lanes, input int ser);
        return lanes * ser;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/adc_sample_format.sv
// Combinational per-channel formatter: offset-binary pass-through (zero-extended)
// or conversion to two's complement (MSB inverted, sign-extended).
module adc_sample_format #(
    parameter int SAMPLE_W = 14,
    parameter int OUT_W    = 16
) (
    input  logic [SAMPLE_W-1:0] raw,
    input  logic                twos_comp,
    output logic [OUT_W-1:0]    word
);

    logic signed [SAMPLE_W-1:0] flipped;

    always_comb begin
        flipped = raw ^ (SAMPLE_W'(1) << (SAMPLE_W - 1));
        if (twos_comp) begin
            word = OUT_W'(flipped);
        end else begin
            word = OUT_W'(raw);
        end
    end

endmodule

// File: rtl/adc_frame_aligner.sv
// Frame alignment and sample unpacking behind the SERDES: hunts the frame word via
// bitslip, tracks lock, and registers formatted per-channel samples with a valid strobe.
module adc_frame_aligner
    import adc_rx_pkg::*;
#(
    parameter int             NUM_CH        = 2,
    parameter int             LANES         = 2,
    parameter int             SER           = 7,
    parameter int             OUT_W         = 16,
    parameter logic [SER-1:0] FRAME_PATTERN = SER'(DEFAULT_FRAME_PATTERN),
    parameter int             LOCK_CNT      = 16,
    parameter int             ERR_LIMIT     = 4,
    parameter int             SLIP_WAIT     = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SER-1:0]                frame_in,
    input  logic [NUM_CH*LANES*SER-1:0]   lane_in,
    input  logic                          twos_comp,
    input  logic                          resync,
    output logic                          bitslip,
    output logic [NUM_CH*OUT_W-1:0]       data_out,
    output logic                          data_valid,
    output logic                          locked,
    output logic                          align_fail,
    output logic [7:0]                    slip_count,
    output logic [7:0]                    unlock_count
);

    localparam int SAMPLE_W = sample_width(LANES, SER);
    localparam int MATCH_W  = $clog2(LOCK_CNT + 1);
    localparam int ERR_W    = $clog2(ERR_LIMIT + 1);
    localparam int SETTLE_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

    localparam logic [MATCH_W-1:0]  LOCK_TARGET = MATCH_W'(LOCK_CNT);
    localparam logic [ERR_W-1:0]    ERR_TARGET  = ERR_W'(ERR_LIMIT);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'((SLIP_WAIT > 0) ? SLIP_WAIT - 1 : 0);
    localparam logic [7:0]          FAIL_SLIPS  = 8'(2 * SER);

    align_state_e          state_q, state_d;
    logic [MATCH_W-1:0]    match_cnt_q, match_cnt_d;
    logic [ERR_W-1:0]      err_cnt_q, err_cnt_d;
    logic [SETTLE_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [7:0]            slip_count_q, slip_count_d;
    logic [7:0]            unlock_count_q, unlock_count_d;
    logic                  align_fail_q, align_fail_d;
    logic                  bitslip_q, bitslip_d;
    logic                  locked_q, locked_d;
    logic                  data_valid_q, data_valid_d;
    logic [NUM_CH*OUT_W-1:0] data_out_q, data_out_d;
    logic [NUM_CH*OUT_W-1:0] fmt_word;
    logic                  match;
    logic                  do_slip;

    assign match = (frame_in == FRAME_PATTERN);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        adc_sample_format #(
            .SAMPLE_W (SAMPLE_W),
            .OUT_W    (OUT_W)
        ) u_fmt (
            .raw       (lane_in[c*LANES*SER +: SAMPLE_W]),
            .twos_comp (twos_comp),
            .word      (fmt_word[c*OUT_W +: OUT_W])
        );
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_d        = state_q;
        match_cnt_d    = match_cnt_q;
        err_cnt_d      = err_cnt_q;
        settle_cnt_d   = settle_cnt_q;
        slip_count_d   = slip_count_q;
        unlock_count_d = unlock_count_q;
        align_fail_d   = align_fail_q;
        bitslip_d      = 1'b0;
        do_slip        = 1'b0;

        if (resync) begin
            state_d      = ST_HUNT;
            match_cnt_d  = '0;
            err_cnt_d    = '0;
            settle_cnt_d = '0;
            slip_count_d = '0;
            align_fail_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_HUNT: begin
                    if (match) begin
                        match_cnt_d = MATCH_W'(1);
                        state_d     = (LOCK_CNT <= 1) ? ST_LOCKED : ST_CHECK;
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SETTLE_LAST) begin
                        state_d = ST_HUNT;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (match) begin
                        match_cnt_d = match_cnt_q + 1'b1;
                        if (match_cnt_d == LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        do_slip = 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (match) begin
                        err_cnt_d = '0;
                    end else begin
                        err_cnt_d = err_cnt_q + 1'b1;
                        if (err_cnt_d == ERR_TARGET) begin
                            state_d        = ST_HUNT;
                            err_cnt_d      = '0;
                            match_cnt_d    = '0;
                            slip_count_d   = '0;
                            unlock_count_d = sat_inc8(unlock_count_q);
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase

            // A slip always restarts the match run and the settle window.
            if (do_slip) begin
                bitslip_d    = 1'b1;
                slip_count_d = sat_inc8(slip_count_q);
                match_cnt_d  = '0;
                settle_cnt_d = '0;
                state_d      = (SLIP_WAIT == 0) ? ST_HUNT : ST_SETTLE;
            end

            if (state_d != ST_LOCKED && slip_count_d >= FAIL_SLIPS) begin
                align_fail_d = 1'b1;
            end
        end

        locked_d     = (state_d == ST_LOCKED);
        data_valid_d = (state_q == ST_LOCKED) && match;
        data_out_d   = fmt_word;
    end

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            state_q        <= ST_HUNT;
            match_cnt_q    <= '0;
            err_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            slip_count_q   <= '0;
            unlock_count_q <= '0;
            align_fail_q   <= 1'b0;
            bitslip_q      <= 1'b0;
            locked_q       <= 1'b0;
            data_valid_q   <= 1'b0;
            data_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            match_cnt_q    <= match_cnt_d;
            err_cnt_q      <= err_cnt_d;
            settle_cnt_q   <= settle_cnt_d;
            slip_count_q   <= slip_count_d;
            unlock_count_q <= unlock_count_d;
            align_fail_q   <= align_fail_d;
            bitslip_q      <= bitslip_d;
            locked_q       <= locked_d;
            data_valid_q   <= data_valid_d;
            data_out_q     <= data_out_d;
        end
    end

    assign bitslip      = bitslip_q;
    assign data_out     = data_out_q;
    assign data_valid   = data_valid_q;
    assign locked       = locked_q;
    assign align_fail   = align_fail_q;
    assign slip_count   = slip_count_q;
    assign unlock_count = unlock_count_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// Self-checking bench for adc_frame_aligner: vector table for formatting, a rotating
// deserializer model for alignment, and randomized locked traffic against a reference.
module tb_adc_frame_aligner;

    localparam int NUM_CH = 2;
    localparam int LANES  = 2;
    localparam int SER    = 7;
    localparam int OUT_W  = 16;
    localparam int SW     = LANES * SER;
    localparam logic [SER-1:0] PATTERN = 7'b1111000;

    logic                        clk;
    logic                        reset_n;
    logic [SER-1:0]              frame_in;
    logic [NUM_CH*LANES*SER-1:0] lane_in;
    logic                        twos_comp;
    logic                        resync;
    logic                        bitslip;
    logic [NUM_CH*OUT_W-1:0]     data_out;
    logic                        data_valid;
    logic                        locked;
    logic                        align_fail;
    logic [7:0]                  slip_count;
    logic [7:0]                  unlock_count;

    adc_frame_aligner #(
        .NUM_CH(NUM_CH), .LANES(LANES), .SER(SER), .OUT_W(OUT_W),
        .FRAME_PATTERN(PATTERN), .LOCK_CNT(16), .ERR_LIMIT(4), .SLIP_WAIT(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .frame_in(frame_in), .lane_in(lane_in),
        .twos_comp(twos_comp), .resync(resync), .bitslip(bitslip), .data_out(data_out),
        .data_valid(data_valid), .locked(locked), .align_fail(align_fail),
        .slip_count(slip_count), .unlock_count(unlock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Deserializer model: misalign bits of rotation, each bitslip pulse removes one.
    int  misalign    = 0;
    bit  force_bad   = 1'b0;
    bit  never_match = 1'b0;
    int  cycle       = 0;
    int  slips_seen  = 0;
    int  slip_cyc[$];

    typedef struct {
        logic [NUM_CH*LANES*SER-1:0] lane;
        logic                        twos;
        logic [NUM_CH*OUT_W-1:0]     exp;
    } fmt_vec_t;

    fmt_vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        check_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic [SER-1:0] rotl(input logic [SER-1:0] v, input int n);
        logic [SER-1:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = {r[SER-2:0], r[SER-1]};
        return r;
    endfunction

    function automatic logic [SER-1:0] frame_word();
        if (never_match) return '0;
        if (force_bad) return ~PATTERN;
        return rotl(PATTERN, misalign);
    endfunction

    // Reference formatter: offset binary to two's complement is subtracting half scale.
    function automatic logic [NUM_CH*OUT_W-1:0] ref_format(input logic [NUM_CH*LANES*SER-1:0] lane,
                                                           input logic twos);
        logic [NUM_CH*OUT_W-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            int raw;
            int v;
            raw = int'((lane >> (c * SW)) & ((1 << SW) - 1));
            v = twos ? raw - (1 << (SW - 1)) : raw;
            r[c*OUT_W +: OUT_W] = 16'(v);
        end
        return r;
    endfunction

    task automatic drive();
        frame_in = frame_word();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cycle++;
        if (bitslip === 1'b1) begin
            slips_seen++;
            slip_cyc.push_back(cycle);
            misalign = (misalign + SER - 1) % SER;
        end
        drive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int burst;
        int lock_step;
        logic [NUM_CH*OUT_W-1:0] exp_out;
        logic exp_dv;

        vecs[0] = '{lane: {14'h3FFF, 14'h0000}, twos: 1'b0, exp: 32'h3FFF_0000};
        vecs[1] = '{lane: {14'h3FFF, 14'h0000}, twos: 1'b1, exp: 32'h1FFF_E000};
        vecs[2] = '{lane: {14'h1FFF, 14'h2000}, twos: 1'b1, exp: 32'hFFFF_0000};
        vecs[3] = '{lane: {14'h1FFF, 14'h2000}, twos: 1'b0, exp: 32'h1FFF_2000};
        vecs[4] = '{lane: {14'h2ABC, 14'h1234}, twos: 1'b1, exp: 32'h0ABC_F234};

        reset_n   = 1'b0;
        lane_in   = '0;
        twos_comp = 1'b0;
        resync    = 1'b0;
        drive();
        step();
        step();
        check("rst_bitslip", 32'(bitslip), 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_valid", 32'(data_valid), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_align_fail", 32'(align_fail), 0);
        check("rst_slip_count", 32'(slip_count), 0);
        check("rst_unlock_count", 32'(unlock_count), 0);

        // Aligned start: lock after 16 matches, valid one frame later, no slips.
        reset_n = 1'b1;
        slips_seen = 0;
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i <= 16) check("aligned_lock_rise", 32'(locked), 32'(i == 16));
            if (i >= 16) check("aligned_first_valid", 32'(data_valid), 32'(i == 17));
        end
        check("aligned_slip_count", 32'(slip_count), 0);
        check("aligned_no_bitslip", 32'(slips_seen), 0);

        for (int v = 0; v < 5; v++) begin
            lane_in   = vecs[v].lane;
            twos_comp = vecs[v].twos;
            drive();
            step();
            check("fmt_vec_data", data_out, vecs[v].exp);
            check("fmt_vec_valid", 32'(data_valid), 1);
        end

        // Random locked traffic with bad-frame bursts too short to unlock.
        burst = 0;
        for (int n = 0; n < 300; n++) begin
            lane_in   = 28'($urandom);
            twos_comp = 1'($urandom_range(0, 1));
            force_bad = (burst < 3) && ($urandom_range(0, 5) == 0);
            burst     = force_bad ? burst + 1 : 0;
            exp_out   = ref_format(lane_in, twos_comp);
            exp_dv    = !force_bad;
            drive();
            step();
            check("rand_data_out", data_out, exp_out);
            check("rand_data_valid", 32'(data_valid), 32'(exp_dv));
            check("rand_locked", 32'(locked), 1);
        end
        force_bad = 1'b0;
        drive();
        step();
        check("rand_tail_valid", 32'(data_valid), 1);

        // Three bad frames: lock holds, exactly those frames dropped.
        force_bad = 1'b1;
        drive();
        for (int k = 1; k <= 3; k++) begin
            step();
            check("bad3_valid", 32'(data_valid), 0);
            check("bad3_locked", 32'(locked), 1);
        end
        force_bad = 1'b0;
        drive();
        step();
        check("bad3_recover_valid", 32'(data_valid), 1);

        // Four bad frames: unlock on the fourth, then re-hunt and relock.
        force_bad = 1'b1;
        drive();
        for (int k = 1; k <= 4; k++) begin
            step();
            check("bad4_locked", 32'(locked), 32'(k < 4));
            check("bad4_valid", 32'(data_valid), 0);
        end
        check("bad4_unlock_count", 32'(unlock_count), 1);
        force_bad = 1'b0;
        drive();
        for (int k = 1; k <= 16; k++) begin
            step();
            check("relock", 32'(locked), 32'(k == 16));
        end
        check("relock_slip_count", 32'(slip_count), 0);

        // resync coincident with the 16th match wins over the lock transition.
        resync = 1'b1;
        drive();
        step();
        resync = 1'b0;
        check("resync_locked", 32'(locked), 0);
        check("resync_align_fail", 32'(align_fail), 0);
        for (int k = 1; k <= 15; k++) step();
        resync = 1'b1;
        step();
        resync = 1'b0;
        check("resync_16th_locked", 32'(locked), 0);
        check("resync_unlock_kept", 32'(unlock_count), 1);
        for (int k = 1; k <= 16; k++) begin
            step();
            check("resync_relock", 32'(locked), 32'(k == 16));
        end

        // Three-bit misalignment through the rotating deserializer.
        reset_n  = 1'b0;
        misalign = 3;
        drive();
        step();
        reset_n    = 1'b1;
        slips_seen = 0;
        slip_cyc.delete();
        lock_step  = -1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (locked === 1'b1) begin
                lock_step = k;
                break;
            end
        end
        check("mis3_lock_step", 32'(lock_step), 28);
        check("mis3_slips_seen", 32'(slips_seen), 3);
        check("mis3_slip_count", 32'(slip_count), 3);
        check("mis3_spacing_a", 32'((slip_cyc.size() >= 3) ? slip_cyc[1] - slip_cyc[0] : -1), 4);
        check("mis3_spacing_b", 32'((slip_cyc.size() >= 3) ? slip_cyc[2] - slip_cyc[1] : -1), 4);

        // Reset while in SETTLE: no pulse under reset, hunting resumes afterwards.
        reset_n  = 1'b0;
        misalign = 3;
        drive();
        step();
        reset_n = 1'b1;
        drive();
        step();
        check("mid_first_slip", 32'(bitslip), 1);
        step();
        reset_n = 1'b0;
        step();
        check("mid_reset_bitslip", 32'(bitslip), 0);
        check("mid_reset_slip_count", 32'(slip_count), 0);
        reset_n = 1'b1;
        drive();
        step();
        check("mid_reset_hunt_slip", 32'(bitslip), 1);

        // Frame never matches: align_fail at the 14th slip, counter saturates.
        reset_n     = 1'b0;
        never_match = 1'b1;
        drive();
        step();
        reset_n    = 1'b1;
        slips_seen = 0;
        for (int k = 1; k <= 1100; k++) begin
            step();
            if (bitslip === 1'b1) begin
                if (slips_seen == 13) check("fail_before_14", 32'(align_fail), 0);
                if (slips_seen == 14) check("fail_at_14", 32'(align_fail), 1);
                if (slips_seen == 255) check("sat_at_255", 32'(slip_count), 255);
                if (slips_seen == 270) check("sat_held", 32'(slip_count), 255);
            end
        end
        check("never_align_fail", 32'(align_fail), 1);
        check("never_locked", 32'(locked), 0);
        check("never_hunting_continues", 32'(slips_seen > 255), 1);

        resync = 1'b1;
        drive();
        step();
        resync = 1'b0;
        check("resync_clears_fail", 32'(align_fail), 0);
        check("resync_clears_slips", 32'(slip_count), 0);
        check("resync_no_unlock", 32'(unlock_count), 0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
